// File: rtl/parking_keypad_auth.sv
// -----------------------------------------------------------------------------
// parking_keypad_auth
//
// Keypad password checker sitting directly upstream of the parking FSM.
// After an entry request it collects BCD digits, compares them against a fixed
// code when Enter is pressed and reports the verdict as a one-cycle pulse on
// result_valid, with correct_password qualifying it. Consecutive failures are
// counted, and reaching MAX_FAILS locks the keypad for LOCKOUT_CYCLES cycles.
//
// Ports
//   clk               clock, rising edge
//   rstn              reset, asynchronous, active-high (historic name)
//   start             entry request, only honoured in IDLE
//   key_valid         one-cycle strobe per keypress
//   key_code          0-9 digit, E clear, F enter, A-D ignored (timer restart)
//   busy              high in every state except IDLE
//   result_valid      one-cycle verdict pulse (PASS or FAIL)
//   correct_password  high only in PASS, coincident with result_valid
//   locked            high while the lockout is running
//   digit_count       number of digits currently held in the buffer
//   fail_count        consecutive failures since the last PASS or lockout
// -----------------------------------------------------------------------------
module parking_keypad_auth #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] CODE           = 16'h1234,
    parameter int                  TIMEOUT_CYCLES = 1000,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 5000
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic                           key_valid,
    input  logic [3:0]                     key_code,
    output logic                           busy,
    output logic                           result_valid,
    output logic                           correct_password,
    output logic                           locked,
    output logic [$clog2(DIGITS+1)-1:0]    digit_count,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int DCW = $clog2(DIGITS + 1);
    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam int LW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0]  LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [DCW-1:0] DIGITS_C   = DCW'(DIGITS);
    localparam logic [FCW-1:0] LAST_FAIL  = FCW'(MAX_FAILS - 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CHECK,
        PASS,
        FAIL,
        LOCKED
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [4*DIGITS-1:0]   buffer;
    logic                  overflow;
    logic [TW-1:0]         timer;
    logic [LW-1:0]         lock_cnt;

    logic is_digit;
    logic is_clear;
    logic is_enter;
    logic match;
    logic timed_out;

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_clear  = key_valid && (key_code == 4'hE);
    assign is_enter  = key_valid && (key_code == 4'hF);
    assign match     = (digit_count == DIGITS_C) && !overflow && (buffer == CODE);
    // A keypress in the final timer cycle still counts; only a silent cycle expires.
    assign timed_out = !key_valid && (timer == TIMER_LAST);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs decode the registered state only, so nothing combinational
    // reaches them from the keypad inputs.
    always_comb begin
        state_next       = state;
        busy             = (state != IDLE);
        result_valid     = 1'b0;
        correct_password = 1'b0;
        locked           = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (is_enter) begin
                    state_next = CHECK;
                end else if (timed_out) begin
                    state_next = FAIL;
                end
            end
            CHECK: begin
                state_next = match ? PASS : FAIL;
            end
            PASS: begin
                result_valid     = 1'b1;
                correct_password = 1'b1;
                state_next       = IDLE;
            end
            FAIL: begin
                result_valid = 1'b1;
                state_next   = (fail_count == LAST_FAIL) ? LOCKED : IDLE;
            end
            LOCKED: begin
                locked = 1'b1;
                if (lock_cnt == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Buffer, counters and timers. Each state touches only the registers it
    // owns; everything else simply holds its value.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            buffer      <= '0;
            digit_count <= '0;
            overflow    <= 1'b0;
            timer       <= '0;
            lock_cnt    <= '0;
            fail_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        buffer      <= '0;
                        digit_count <= '0;
                        overflow    <= 1'b0;
                        timer       <= '0;
                    end
                end
                COLLECT: begin
                    if (key_valid) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                    if (is_digit) begin
                        if (digit_count < DIGITS_C) begin
                            // The oldest digit ends up in the most significant nibble.
                            buffer      <= (4*DIGITS)'({buffer, key_code});
                            digit_count <= digit_count + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (is_clear) begin
                        buffer      <= '0;
                        digit_count <= '0;
                        overflow    <= 1'b0;
                    end
                end
                PASS: begin
                    fail_count <= '0;
                end
                FAIL: begin
                    // The failure that trips the lockout is not added to the
                    // count; the lockout expiry clears it instead.
                    if (fail_count == LAST_FAIL) begin
                        lock_cnt <= LOCK_LOAD;
                    end else begin
                        fail_count <= fail_count + 1'b1;
                    end
                end
                LOCKED: begin
                    if (lock_cnt == '0) begin
                        fail_count <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parking_keypad_auth.sv
// -----------------------------------------------------------------------------
// tb_parking_keypad_auth
//
// Self-checking bench for parking_keypad_auth. Scenario tasks drive keypad
// sequences and compare observations against expectations derived from a
// small behavioural model: the digits held since the last clear are kept in a
// queue and compared as a number, and failures are tracked with an integer.
// Short timeout/lockout parameters keep the run brief.
// -----------------------------------------------------------------------------
module tb_parking_keypad_auth;

    localparam int          DIGITS    = 4;
    localparam logic [15:0] CODE      = 16'h1234;
    localparam int          TIMEOUT   = 20;
    localparam int          MAX_FAILS = 3;
    localparam int          LOCKOUT   = 50;
    localparam int          DCW       = $clog2(DIGITS + 1);
    localparam int          FCW       = $clog2(MAX_FAILS + 1);

    logic           clk       = 1'b0;
    logic           rstn      = 1'b1;
    logic           start     = 1'b0;
    logic           key_valid = 1'b0;
    logic [3:0]     key_code  = 4'h0;
    logic           busy;
    logic           result_valid;
    logic           correct_password;
    logic           locked;
    logic [DCW-1:0] digit_count;
    logic [FCW-1:0] fail_count;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_fails = 0;
    bit noisy = 1'b0;

    logic [3:0] key_q[$];
    int         gap_q[$];

    parking_keypad_auth #(
        .DIGITS         (DIGITS),
        .CODE           (CODE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_FAILS      (MAX_FAILS),
        .LOCKOUT_CYCLES (LOCKOUT)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .start            (start),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .busy             (busy),
        .result_valid     (result_valid),
        .correct_password (correct_password),
        .locked           (locked),
        .digit_count      (digit_count),
        .fail_count       (fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    // Verdict the keypad should give for the sequence in key_q.
    function automatic bit model_pass();
        int held[$];
        int value;
        bit done;
        done = 1'b0;
        foreach (key_q[i]) begin
            if (!done) begin
                if (key_q[i] <= 4'd9) held.push_back(int'(key_q[i]));
                else if (key_q[i] == 4'hE) held.delete();
                else if (key_q[i] == 4'hF) done = 1'b1;
            end
        end
        if (held.size() != DIGITS) return 1'b0;
        value = 0;
        foreach (held[i]) value = value * 16 + held[i];
        return value == int'(CODE);
    endfunction

    // Consecutive-failure bookkeeping; fc_next is the count seen right after the pulse.
    function automatic void model_update(input bit pass, output bit lock, output int fc_next);
        if (pass) begin
            exp_fails = 0;
            lock      = 1'b0;
            fc_next   = 0;
        end else if (exp_fails + 1 >= MAX_FAILS) begin
            lock      = 1'b1;
            fc_next   = exp_fails;
            exp_fails = 0;
        end else begin
            exp_fails = exp_fails + 1;
            lock      = 1'b0;
            fc_next   = exp_fails;
        end
    endfunction

    // Runs start + key_q, reports verdict latency after Enter, the verdict and the state one cycle later.
    task automatic do_entry(output int lat, output logic cp, output logic rv_after,
                            output logic [FCW-1:0] fc_after, output logic lk_after);
        start = 1'b1;
        tick();
        start = 1'b0;
        foreach (key_q[i]) begin
            repeat (gap_q[i]) begin
                if (noisy) start = 1'($urandom_range(0, 1));
                tick();
            end
            press(key_q[i]);
        end
        start = 1'b0;
        lat = 0;
        while (result_valid !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        cp = correct_password;
        tick();
        rv_after = result_valid;
        fc_after = fail_count;
        lk_after = locked;
    endtask

    // Counts locked cycles while hammering start and keys.
    task automatic wait_lock(output int cnt);
        cnt = 0;
        while (locked === 1'b1 && cnt < LOCKOUT + 10) begin
            cnt++;
            start     = 1'($urandom_range(0, 1));
            key_valid = 1'($urandom_range(0, 1));
            key_code  = 4'($urandom_range(0, 15));
            tick();
        end
        start     = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic load_keys(input logic [3:0] k0, input int n, input logic [3:0] k1,
                             input logic [3:0] k2, input logic [3:0] k3, input logic [3:0] k4,
                             input logic [3:0] k5);
        logic [3:0] ks[6];
        ks = '{k0, k1, k2, k3, k4, k5};
        key_q.delete();
        gap_q.delete();
        for (int i = 0; i < n; i++) begin
            key_q.push_back(ks[i]);
            gap_q.push_back(0);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({busy, result_valid, correct_password, locked} !== 4'b0000) begin
            n_fails++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {busy, result_valid, correct_password, locked});
        end
        rstn = 1'b0;
        tick();
        n_checks++;
        if ({digit_count, fail_count} !== '0 || busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_counts: got dc=%0d fc=%0d busy=%b want 0 0 0", digit_count, fail_count, busy);
        end
    endtask

    task automatic test_pass_basic();
        int lat; logic cp, rv2, lk; logic [FCW-1:0] fc; bit pass, lock; int efc;
        load_keys(4'h1, 5, 4'h2, 4'h3, 4'h4, 4'hF, 4'h0);
        pass = model_pass();
        model_update(pass, lock, efc);
        do_entry(lat, cp, rv2, fc, lk);
        n_checks++;
        if (lat !== 1) begin n_fails++; $display("[TB] FAIL pass_latency: got %0d want 1", lat); end
        n_checks++;
        if (cp !== pass) begin n_fails++; $display("[TB] FAIL pass_correct: got %b want %b", cp, pass); end
        n_checks++;
        if (rv2 !== 1'b0) begin n_fails++; $display("[TB] FAIL pass_pulse_width: got rv=%b want 0", rv2); end
        n_checks++;
        if (fc !== FCW'(efc) || busy !== 1'b0) begin
            n_fails++; $display("[TB] FAIL pass_after: got fc=%0d busy=%b want %0d 0", fc, busy, efc);
        end
    endtask

    task automatic test_fail_overflow();
        int lat; logic cp, rv2, lk; logic [FCW-1:0] fc; bit pass, lock; int efc;
        load_keys(4'h1, 4, 4'h2, 4'h3, 4'hF, 4'h0, 4'h0);
        pass = model_pass();
        model_update(pass, lock, efc);
        do_entry(lat, cp, rv2, fc, lk);
        n_checks++;
        if (lat !== 1 || cp !== 1'b0) begin
            n_fails++; $display("[TB] FAIL short_code: got lat=%0d cp=%b want 1 0", lat, cp);
        end
        n_checks++;
        if (fc !== FCW'(efc)) begin n_fails++; $display("[TB] FAIL short_code_fc: got %0d want %0d", fc, efc); end
        load_keys(4'h1, 6, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF);
        pass = model_pass();
        model_update(pass, lock, efc);
        do_entry(lat, cp, rv2, fc, lk);
        n_checks++;
        if (lat !== 1 || cp !== 1'b0) begin
            n_fails++; $display("[TB] FAIL overflow: got lat=%0d cp=%b want 1 0", lat, cp);
        end
        n_checks++;
        if (fc !== FCW'(efc) || lk !== 1'b0) begin
            n_fails++; $display("[TB] FAIL overflow_fc: got fc=%0d lk=%b want %0d 0", fc, lk, efc);
        end
    endtask

    task automatic test_clear();
        bit lock; int efc;
        start = 1'b1;
        tick();
        start = 1'b0;
        press(4'h9);
        press(4'h9);
        press(4'hE);
        n_checks++;
        if (digit_count !== DCW'(0)) begin n_fails++; $display("[TB] FAIL clear_count: got %0d want 0", digit_count); end
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        n_checks++;
        if (digit_count !== DCW'(4)) begin n_fails++; $display("[TB] FAIL clear_refill: got %0d want 4", digit_count); end
        press(4'hF);
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || correct_password !== 1'b1) begin
            n_fails++; $display("[TB] FAIL clear_pass: got rv=%b cp=%b want 1 1", result_valid, correct_password);
        end
        model_update(1'b1, lock, efc);
        tick();
        n_checks++;
        if (fail_count !== FCW'(efc)) begin n_fails++; $display("[TB] FAIL clear_fc: got %0d want %0d", fail_count, efc); end
    endtask

    task automatic test_lockout();
        int lat, cnt, efc; logic cp, rv2, lk; logic [FCW-1:0] fc; bit pass, lock;
        for (int n = 0; n < MAX_FAILS; n++) begin
            load_keys(4'h9, 5, 4'h9, 4'h9, 4'h9, 4'hF, 4'h0);
            pass = model_pass();
            model_update(pass, lock, efc);
            do_entry(lat, cp, rv2, fc, lk);
            n_checks++;
            if (cp !== 1'b0 || lk !== lock || fc !== FCW'(efc)) begin
                n_fails++;
                $display("[TB] FAIL lockout_fail%0d: got cp=%b lk=%b fc=%0d want 0 %b %0d", n, cp, lk, fc, lock, efc);
            end
        end
        wait_lock(cnt);
        n_checks++;
        if (cnt !== LOCKOUT) begin n_fails++; $display("[TB] FAIL lockout_len: got %0d want %0d", cnt, LOCKOUT); end
        tick();
        n_checks++;
        if (busy !== 1'b0 || fail_count !== FCW'(0) || locked !== 1'b0) begin
            n_fails++; $display("[TB] FAIL lockout_exit: got busy=%b fc=%0d lk=%b want 0 0 0", busy, fail_count, locked);
        end
        load_keys(4'h1, 5, 4'h2, 4'h3, 4'h4, 4'hF, 4'h0);
        pass = model_pass();
        model_update(pass, lock, efc);
        do_entry(lat, cp, rv2, fc, lk);
        n_checks++;
        if (lat !== 1 || cp !== 1'b1) begin
            n_fails++; $display("[TB] FAIL lockout_then_pass: got lat=%0d cp=%b want 1 1", lat, cp);
        end
    endtask

    task automatic test_timeout();
        int cnt, efc; bit lock;
        start = 1'b1;
        tick();
        start = 1'b0;
        press(4'h1);
        cnt = 0;
        while (result_valid !== 1'b1 && cnt < 3 * TIMEOUT) begin tick(); cnt++; end
        n_checks++;
        if (cnt !== TIMEOUT || correct_password !== 1'b0) begin
            n_fails++; $display("[TB] FAIL timeout_len: got %0d cp=%b want %0d 0", cnt, correct_password, TIMEOUT);
        end
        model_update(1'b0, lock, efc);
        tick();
        n_checks++;
        if (fail_count !== FCW'(efc)) begin n_fails++; $display("[TB] FAIL timeout_fc: got %0d want %0d", fail_count, efc); end
        start = 1'b1;
        tick();
        start = 1'b0;
        press(4'h1);
        repeat (TIMEOUT - 3) tick();
        press(4'hA);
        n_checks++;
        if (digit_count !== DCW'(1) || result_valid !== 1'b0) begin
            n_fails++; $display("[TB] FAIL ignored_key: got dc=%0d rv=%b want 1 0", digit_count, result_valid);
        end
        cnt = 0;
        while (result_valid !== 1'b1 && cnt < 3 * TIMEOUT) begin tick(); cnt++; end
        n_checks++;
        if (cnt !== TIMEOUT) begin n_fails++; $display("[TB] FAIL timer_restart: got %0d want %0d", cnt, TIMEOUT); end
        model_update(1'b0, lock, efc);
        tick();
        n_checks++;
        if (fail_count !== FCW'(efc) || locked !== lock) begin
            n_fails++; $display("[TB] FAIL timeout2_fc: got fc=%0d lk=%b want %0d %b", fail_count, locked, efc, lock);
        end
    endtask

    task automatic test_back_to_back();
        int efc; bit lock;
        start     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h1;
        tick();
        start     = 1'b0;
        key_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || digit_count !== DCW'(0)) begin
            n_fails++; $display("[TB] FAIL start_with_key: got busy=%b dc=%0d want 1 0", busy, digit_count);
        end
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        press(4'hF);
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1) begin
            n_fails++; $display("[TB] FAIL check_cycle: got rv=%b busy=%b want 0 1", result_valid, busy);
        end
        tick();
        n_checks++;
        if (result_valid !== 1'b1 || correct_password !== 1'b1) begin
            n_fails++; $display("[TB] FAIL b2b_pass: got rv=%b cp=%b want 1 1", result_valid, correct_password);
        end
        model_update(1'b1, lock, efc);
        tick();
        n_checks++;
        if (fail_count !== FCW'(efc) || busy !== 1'b0) begin
            n_fails++; $display("[TB] FAIL b2b_after: got fc=%0d busy=%b want %0d 0", fail_count, busy, efc);
        end
    endtask

    task automatic test_random();
        int lat, cnt, efc, len; logic cp, rv2, lk; logic [FCW-1:0] fc; bit pass, lock;
        logic [15:0] code_v;
        int r;
        code_v = CODE;
        noisy  = 1'b1;
        for (int it = 0; it < 30; it++) begin
            key_q.delete();
            gap_q.delete();
            if ($urandom_range(0, 9) < 4) begin
                if ($urandom_range(0, 1) == 1) begin
                    len = $urandom_range(1, 6);
                    for (int j = 0; j < len; j++) key_q.push_back(4'($urandom_range(0, 9)));
                    key_q.push_back(4'hE);
                end
                for (int j = DIGITS - 1; j >= 0; j--) key_q.push_back(code_v[4*j +: 4]);
            end else begin
                len = $urandom_range(0, 6);
                for (int j = 0; j < len; j++) begin
                    r = $urandom_range(0, 19);
                    if (r < 14) key_q.push_back(4'($urandom_range(0, 9)));
                    else if (r < 17) key_q.push_back(4'($urandom_range(10, 13)));
                    else key_q.push_back(4'hE);
                end
            end
            key_q.push_back(4'hF);
            foreach (key_q[j]) gap_q.push_back($urandom_range(0, 4));
            pass = model_pass();
            model_update(pass, lock, efc);
            do_entry(lat, cp, rv2, fc, lk);
            n_checks++;
            if (lat !== 1 || cp !== pass || rv2 !== 1'b0 || fc !== FCW'(efc) || lk !== lock) begin
                n_fails++;
                $display("[TB] FAIL random_%0d: got lat=%0d cp=%b rv2=%b fc=%0d lk=%b want 1 %b 0 %0d %b",
                         it, lat, cp, rv2, fc, lk, pass, efc, lock);
            end
            if (lock) begin
                wait_lock(cnt);
                n_checks++;
                if (cnt !== LOCKOUT) begin n_fails++; $display("[TB] FAIL random_lock_%0d: got %0d want %0d", it, cnt, LOCKOUT); end
            end
        end
        noisy = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, efc; logic cp, rv2, lk; logic [FCW-1:0] fc; bit pass, lock;
        start = 1'b1;
        tick();
        start = 1'b0;
        press(4'h1);
        press(4'h2);
        rstn = 1'b1;
        #2;
        n_checks++;
        if ({busy, result_valid, correct_password, locked, digit_count, fail_count} !== '0) begin
            n_fails++; $display("[TB] FAIL reset_mid_collect: got busy=%b dc=%0d fc=%0d want 0 0 0", busy, digit_count, fail_count);
        end
        tick();
        rstn = 1'b0;
        exp_fails = 0;
        for (int n = 0; n < MAX_FAILS; n++) begin
            load_keys(4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
            pass = model_pass();
            model_update(pass, lock, efc);
            do_entry(lat, cp, rv2, fc, lk);
        end
        n_checks++;
        if (locked !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_pre_lock: got %b want 1", locked); end
        repeat (5) tick();
        rstn = 1'b1;
        #2;
        n_checks++;
        if (locked !== 1'b0 || fail_count !== FCW'(0) || busy !== 1'b0) begin
            n_fails++; $display("[TB] FAIL reset_mid_lock: got lk=%b fc=%0d busy=%b want 0 0 0", locked, fail_count, busy);
        end
        tick();
        rstn = 1'b0;
        exp_fails = 0;
        load_keys(4'h1, 5, 4'h2, 4'h3, 4'h4, 4'hF, 4'h0);
        pass = model_pass();
        model_update(pass, lock, efc);
        do_entry(lat, cp, rv2, fc, lk);
        n_checks++;
        if (lat !== 1 || cp !== 1'b1 || fc !== FCW'(efc)) begin
            n_fails++; $display("[TB] FAIL reset_then_pass: got lat=%0d cp=%b fc=%0d want 1 1 %0d", lat, cp, fc, efc);
        end
    endtask

    initial begin
        $display("[TB] parking_keypad_auth bench starting");
        test_reset();
        test_pass_basic();
        test_fail_overflow();
        test_clear();
        test_lockout();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
